tx_pac_gen: RTL and testbench

Transmitter-board packet generator: the send-side counterpart of the receiver's packet-start timing. On each frame-start pulse it emits a fixed sequence of back-to-back packets on a byte-wide 125 MHz stream. It uses 16 control packets followed by video packets. Each packet carries a 4-byte header, FIFO-sourced payload and a trailing checksum byte. It sits between the payload FIFO and the serializer/PHY interface.

---
 rtl/tx_pac_pkg.sv | 23 ++
 rtl/tx_pac_cksum.sv | 23 ++
 rtl/tx_pac_gen.sv | 134 +++++++++++++
 tb/tb_tx_pac_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pac_pkg.sv
// Shared types and constants for the transmit packet generator and its
// receive-side checker.
package tx_pac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    CKS  = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] TYPE_CTRL = 8'h01;
  localparam logic [7:0] TYPE_VID  = 8'h02;
  localparam int unsigned HDR_LEN  = 4;

  // Production frame geometry; the generator takes these as parameter defaults.
  localparam int unsigned DEF_CTRL_LEN       = 2071;
  localparam int unsigned DEF_VID_LEN        = 1943;
  localparam int unsigned DEF_CTRL_PKTS      = 16;
  localparam int unsigned DEF_PKTS_PER_FRAME = 1041;

endpackage

// File: rtl/tx_pac_cksum.sv
// 8-bit modulo-256 byte accumulator with synchronous clear and add enable.
// Shared with the receive side, where it recomputes the checksum for comparison.
module tx_pac_cksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] acc_q;

  // Clear wins over add so a packet start always begins from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (add_i) acc_q <= acc_q + byte_i;
  end

  assign sum_o = acc_q;

endmodule

// File: rtl/tx_pac_gen.sv
// Frame packet generator: on int_vp emits CTRL_PKTS control packets followed
// by video packets, back to back, each as header / FIFO payload / checksum.
// state_q, bc_q and pkt_q describe the byte currently on tx_data; the
// combinational "nxt_*" decode describes the byte being registered next.
module tx_pac_gen
  import tx_pac_pkg::*;
#(
  parameter int unsigned CTRL_LEN       = DEF_CTRL_LEN,
  parameter int unsigned VID_LEN        = DEF_VID_LEN,
  parameter int unsigned CTRL_PKTS      = DEF_CTRL_PKTS,
  parameter int unsigned PKTS_PER_FRAME = DEF_PKTS_PER_FRAME
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_vp,
  input  logic [7:0]  pl_data,
  input  logic        pl_empty,
  output logic        pl_rd,
  output logic        pac_stp,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        tx_eop,
  output logic [10:0] pkt_num,
  output logic        underrun
);

  localparam logic [11:0] CLEN     = 12'(CTRL_LEN);
  localparam logic [11:0] VLEN     = 12'(VID_LEN);
  localparam logic [10:0] CPKTS    = 11'(CTRL_PKTS);
  localparam logic [10:0] LAST_PKT = 11'(PKTS_PER_FRAME - 1);
  localparam logic [11:0] HDR_LAST = 12'(HDR_LEN - 1);

  state_e      state_q, nxt_state;
  logic [11:0] bc_q, nxt_bc, cur_len;
  logic [10:0] pkt_q, nxt_pkt;
  logic [7:0]  nxt_data, sum;
  logic        cks_clr, cks_add;
  logic        pac_stp_q, tx_en_q, tx_eop_q, underrun_q;
  logic [7:0]  tx_data_q;

  assign cur_len = (pkt_q < CPKTS) ? CLEN : VLEN;

  // Position of the next byte; int_vp overrides everything and restarts at packet 0.
  always_comb begin
    nxt_state = state_q;
    nxt_bc    = bc_q + 12'd1;
    nxt_pkt   = pkt_q;
    unique case (state_q)
      IDLE: nxt_bc = '0;
      HDR:  if (bc_q == HDR_LAST) nxt_state = PAY;
      PAY:  if (bc_q == cur_len - 12'd2) nxt_state = CKS;
      CKS: begin
        nxt_bc = '0;
        if (pkt_q < LAST_PKT) begin
          nxt_state = HDR;
          nxt_pkt   = pkt_q + 11'd1;
        end else begin
          nxt_state = IDLE;
        end
      end
    endcase
    if (int_vp) begin
      nxt_state = HDR;
      nxt_bc    = '0;
      nxt_pkt   = '0;
    end
  end

  // The FIFO is popped exactly when the next registered byte is payload.
  assign pl_rd = (nxt_state == PAY);

  // Value of the next byte; an empty FIFO on a read substitutes 8'h00.
  always_comb begin
    nxt_data = '0;
    unique case (nxt_state)
      IDLE: nxt_data = '0;
      HDR: begin
        unique case (nxt_bc[1:0])
          2'd0: nxt_data = SYNC_BYTE;
          2'd1: nxt_data = (nxt_pkt < CPKTS) ? TYPE_CTRL : TYPE_VID;
          2'd2: nxt_data = {5'b0, nxt_pkt[10:8]};
          2'd3: nxt_data = nxt_pkt[7:0];
        endcase
      end
      PAY: nxt_data = pl_empty ? 8'h00 : pl_data;
      CKS: nxt_data = sum;
    endcase
  end

  // Sync byte and checksum are excluded from the sum.
  assign cks_clr = (nxt_state == HDR) && (nxt_bc == '0);
  assign cks_add = ((nxt_state == HDR) && (nxt_bc != '0)) || (nxt_state == PAY);

  tx_pac_cksum u_cksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cks_clr),
    .add_i  (cks_add),
    .byte_i (nxt_data),
    .sum_o  (sum)
  );

  // Generator FSM with all stream outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bc_q       <= '0;
      pkt_q      <= '0;
      pac_stp_q  <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_eop_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q   <= nxt_state;
      bc_q      <= nxt_bc;
      pkt_q     <= nxt_pkt;
      pac_stp_q <= cks_clr;
      tx_en_q   <= (nxt_state != IDLE);
      tx_data_q <= nxt_data;
      tx_eop_q  <= (nxt_state == CKS);
      if (int_vp)                 underrun_q <= 1'b0;
      else if (pl_rd && pl_empty) underrun_q <= 1'b1;
    end
  end

  assign pac_stp  = pac_stp_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign tx_eop   = tx_eop_q;
  assign pkt_num  = pkt_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_tx_pac_gen.sv
// Bench for tx_pac_gen with shortened packets (real packet counts) so whole
// frames fit in a short run. A position-based reference model predicts every
// output byte from the frame layout rules.
module tb_tx_pac_gen;

  localparam int CL    = 24;
  localparam int VL    = 12;
  localparam int CP    = 16;
  localparam int NP    = 1041;
  localparam int FRAME = CP * CL + (NP - CP) * VL;

  logic        clk = 1'b0, rst_n = 1'b0, int_vp = 1'b0, pl_empty = 1'b0;
  logic [7:0]  pl_data = 8'h00;
  logic        pl_rd, pac_stp, tx_en, tx_eop, underrun;
  logic [7:0]  tx_data;
  logic [10:0] pkt_num;

  always #4 clk = ~clk;

  tx_pac_gen #(.CTRL_LEN(CL), .VID_LEN(VL), .CTRL_PKTS(CP), .PKTS_PER_FRAME(NP)) dut (
    .clk(clk), .rst_n(rst_n), .int_vp(int_vp), .pl_data(pl_data), .pl_empty(pl_empty),
    .pl_rd(pl_rd), .pac_stp(pac_stp), .tx_en(tx_en), .tx_data(tx_data),
    .tx_eop(tx_eop), .pkt_num(pkt_num), .underrun(underrun)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_act = 1'b0, m_und = 1'b0, rnd_data = 1'b0, rnd_empty = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_q[$];
  logic [7:0] fifo_head = 8'h00;
  bit         e_stp = 0, e_en = 0, e_eop = 0;
  logic [7:0] e_data = 0;
  logic [10:0] e_pkt = 0;

  function automatic int plen(input int p);
    return (p < CP) ? CL : VL;
  endfunction

  function automatic void locate(input int pos, output int p, output int bc);
    if (pos < CP * CL) begin
      p = pos / CL; bc = pos % CL;
    end else begin
      p = CP + (pos - CP * CL) / VL; bc = (pos - CP * CL) % VL;
    end
  endfunction

  function automatic bit exp_rd(input bit vp);
    int p, bc;
    if (vp || !m_act || (m_pos + 1 >= FRAME)) return 1'b0;
    locate(m_pos + 1, p, bc);
    return (bc >= 4) && (bc <= plen(p) - 2);
  endfunction

  task automatic model_edge(input bit vp, input bit empty, input logic [7:0] d);
    int p, bc, len;
    logic [7:0]  b, s;
    logic [10:0] pk;
    if (vp) begin
      m_act = 1; m_pos = 0; m_und = 0;
    end else if (m_act) begin
      m_pos++;
      if (m_pos == FRAME) m_act = 0;
    end
    if (m_act) begin
      locate(m_pos, p, bc);
      len = plen(p);
      pk  = 11'(p);
      if (bc == 0) m_q.delete();
      if (bc == 0)            b = 8'hA5;
      else if (bc == 1)       b = (p < CP) ? 8'h01 : 8'h02;
      else if (bc == 2)       b = {5'b0, pk[10:8]};
      else if (bc == 3)       b = pk[7:0];
      else if (bc == len - 1) begin
        s = 8'h00;
        foreach (m_q[i]) if (i > 0) s = s + m_q[i];
        b = s;
      end else if (empty) begin
        b = 8'h00; m_und = 1;
      end else begin
        b = d;
        fifo_head = rnd_data ? 8'($urandom) : fifo_head + 8'd1;
      end
      m_q.push_back(b);
      e_stp = (bc == 0); e_en = 1; e_eop = (bc == len - 1); e_data = b; e_pkt = pk;
    end else begin
      e_stp = 0; e_en = 0; e_eop = 0; e_data = 8'h00;
    end
  endtask

  // ---------------- observed packet statistics ----------------
  int         cycn = 0, stp_cnt = 0, bcnt = 0, cur = 0, first_stp = 0, last_eop = 0;
  logic [7:0] hdr [NP][4];
  int         plen_act [NP];

  // One clock: drive inputs, check pl_rd, clock, update model, check outputs.
  task automatic cyc(input bit vp, input bit empty);
    logic [7:0] d;
    d = fifo_head;
    int_vp = vp; pl_empty = empty; pl_data = d;
    #1;
    chk("pl_rd", pl_rd, exp_rd(vp));
    @(posedge clk);
    model_edge(vp, empty, d);
    #1;
    chk("tx_en", tx_en, e_en);
    chk("pac_stp", pac_stp, e_stp);
    chk("tx_eop", tx_eop, e_eop);
    chk("tx_data", tx_data, e_data);
    chk("underrun", underrun, m_und);
    if (e_en) chk("pkt_num", pkt_num, e_pkt);
    cycn++;
    if (tx_en === 1'b1) begin
      if (pac_stp === 1'b1) begin
        stp_cnt++; bcnt = 0; cur = int'(pkt_num);
        if (stp_cnt == 1) first_stp = cycn;
      end else bcnt++;
      if (cur < NP && bcnt < 4) hdr[cur][bcnt] = tx_data;
      if (tx_eop === 1'b1) begin
        if (cur < NP) plen_act[cur] = bcnt + 1;
        last_eop = cycn;
      end
    end
  endtask

  task automatic run_to(input int tpos);
    int budget = 20000;
    while (!(m_act && m_pos == tpos) && budget > 0) begin
      cyc(1'b0, rnd_empty ? ($urandom_range(0, 19) == 0) : 1'b0);
      budget--;
    end
    if (budget == 0) chk("run_to timeout", 0, 1);
  endtask

  typedef struct {
    int         pkt;
    logic [7:0] b1, b2, b3;
    int         len;
  } hdr_vec_t;

  hdr_vec_t tbl[6];

  initial begin
    int bad, budget;
    tbl[0] = '{pkt: 0,    b1: 8'h01, b2: 8'h00, b3: 8'h00, len: CL};
    tbl[1] = '{pkt: 15,   b1: 8'h01, b2: 8'h00, b3: 8'h0F, len: CL};
    tbl[2] = '{pkt: 16,   b1: 8'h02, b2: 8'h00, b3: 8'h10, len: VL};
    tbl[3] = '{pkt: 255,  b1: 8'h02, b2: 8'h00, b3: 8'hFF, len: VL};
    tbl[4] = '{pkt: 256,  b1: 8'h02, b2: 8'h01, b3: 8'h00, len: VL};
    tbl[5] = '{pkt: 1040, b1: 8'h02, b2: 8'h04, b3: 8'h10, len: VL};

    // Reset state
    #2;
    chk("rst pl_rd", pl_rd, 0);    chk("rst pac_stp", pac_stp, 0);
    chk("rst tx_en", tx_en, 0);    chk("rst tx_data", tx_data, 0);
    chk("rst tx_eop", tx_eop, 0);  chk("rst pkt_num", pkt_num, 0);
    chk("rst underrun", underrun, 0);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) cyc(0, 0);

    // Full frame, incrementing payload, FIFO never empty
    cyc(1, 0);
    budget = FRAME + 10;
    while (m_act && budget > 0) begin cyc(0, 0); budget--; end
    if (budget == 0) chk("frame timeout", 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0);
    chk("pac_stp count", stp_cnt, NP);
    chk("frame cycles", last_eop - first_stp + 1, FRAME);
    chk("tx_en after frame", tx_en, 0);
    foreach (tbl[i]) begin
      chk($sformatf("pkt%0d type", tbl[i].pkt), hdr[tbl[i].pkt][1], tbl[i].b1);
      chk($sformatf("pkt%0d num_hi", tbl[i].pkt), hdr[tbl[i].pkt][2], tbl[i].b2);
      chk($sformatf("pkt%0d num_lo", tbl[i].pkt), hdr[tbl[i].pkt][3], tbl[i].b3);
      chk($sformatf("pkt%0d len", tbl[i].pkt), plen_act[tbl[i].pkt], tbl[i].len);
    end
    bad = 0;
    for (int i = 0; i < NP; i++) if (plen_act[i] != plen(i)) bad++;
    chk("packet lengths", bad, 0);

    // FIFO empty for 3 payload cycles in packet 2
    foreach (plen_act[i]) plen_act[i] = 0;
    cyc(1, 0);
    run_to(2 * CL + 8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      chk("underrun byte", tx_data, 8'h00);
    end
    chk("underrun set", underrun, 1);
    run_to(3 * CL + 2);
    chk("pkt2 len with underrun", plen_act[2], CL);
    chk("underrun held", underrun, 1);
    cyc(1, 0);
    chk("underrun cleared by int_vp", underrun, 0);

    // Random payload and FIFO gaps; abort mid-payload of packet 20
    rnd_data = 1; rnd_empty = 1;
    run_to(CP * CL + 4 * VL + 6);
    cyc(1, 0);
    chk("abort no eop", tx_eop, 0);
    chk("abort pac_stp", pac_stp, 1);
    chk("abort pkt_num", pkt_num, 0);
    run_to(CL - 1);
    chk("restart pkt0 eop", tx_eop, 1);

    // Asynchronous reset during payload of packet 5
    run_to(5 * CL + 10);
    int_vp = 1'b0; pl_empty = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst pl_rd", pl_rd, 0);    chk("arst pac_stp", pac_stp, 0);
    chk("arst tx_en", tx_en, 0);    chk("arst tx_data", tx_data, 0);
    chk("arst tx_eop", tx_eop, 0);  chk("arst pkt_num", pkt_num, 0);
    chk("arst underrun", underrun, 0);
    m_act = 0; m_und = 0; e_stp = 0; e_en = 0; e_eop = 0; e_data = 0; e_pkt = 0;
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) cyc(0, 0);

    // int_vp on the final checksum byte restarts immediately
    rnd_data = 0; rnd_empty = 0;
    cyc(1, 0);
    run_to(FRAME - 1);
    chk("final eop", tx_eop, 1);
    chk("final pkt_num", pkt_num, NP - 1);
    cyc(1, 0);
    chk("restart pac_stp", pac_stp, 1);
    chk("restart pkt_num", pkt_num, 0);
    chk("restart sync", tx_data, 8'hA5);
    for (int i = 0; i < 30; i++) cyc(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
